// File: rtl/expr_chk_pkg.sv
// Shared definitions for the expression result checker.
//   state_t   : run-control FSM states of expr_result_misr
//   MISR_POLY : CRC-32 feedback polynomial used by the signature register
//   MISR_SEED : signature value at reset and at the start of every run
//   fold90    : compacts a 90-bit result vector into one 32-bit MISR input word
package expr_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

   // Zero-extend to three full words, then XOR the words together.
   function automatic logic [31:0] fold90(input logic [89:0] d);
      logic [95:0] x;
      x = {6'd0, d};
      return x[31:0] ^ x[63:32] ^ x[95:64];
   endfunction

endpackage

// File: rtl/expr_result_misr_misr32.sv
// 32-bit multiple-input signature register.
//   clk, rst : clock and asynchronous active-high reset (loads the seed)
//   clear    : synchronous reload of the seed (start of a run)
//   enable   : fold one input word into the signature this edge
//   fold     : compacted input word
//   sig      : current signature
module misr32
   import expr_chk_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        enable,
   input  logic [31:0] fold,
   output logic [31:0] sig
);

   logic [31:0] sig_step;

   // Left-shifting Galois step: the bit shifted out selects the feedback.
   assign sig_step = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'd0) ^ fold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= MISR_SEED;
      end else if (clear) begin
         sig <= MISR_SEED;
      end else if (enable) begin
         sig <= sig_step;
      end
   end

endmodule

// File: rtl/expr_result_misr.sv
// Response compactor for the expression regression suite. Accepts one result
// vector per valid/ready handshake, folds it into a 32-bit MISR over a
// programmed number of vectors and compares the final signature with a golden
// value, yielding one pass/fail verdict per run.
//   start, num_vec, golden : launch a run (sampled only in IDLE or DONE)
//   in_valid/in_ready/in_data : result vector stream
//   busy  : run or check in progress
//   done  : verdict available, held until the next start
//   pass  : signature matched golden (meaningful while done)
//   signature, vec_count : live MISR value and accepted-vector count
module expr_result_misr
   import expr_chk_pkg::*;
#(
   parameter int WIDTH = 90,
   parameter int SIG_W = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic [SIG_W-1:0] golden,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] vec_count
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] num_q;
   logic [SIG_W-1:0] golden_q;
   logic             start_ok;
   logic             accept;
   logic [CNT_W-1:0] cnt_inc;
   logic             last;

   assign start_ok = start & ((state == ST_IDLE) | (state == ST_DONE));
   assign accept   = in_valid & in_ready;
   // Saturating increment; never actually reached in a legal run because the
   // count stops at num_vec, but it keeps the counter from wrapping.
   assign cnt_inc  = (vec_count == {CNT_W{1'b1}}) ? vec_count : vec_count + CNT_W'(1);
   assign last     = accept & (cnt_inc == num_q);

   assign busy = (state == ST_RUN) | (state == ST_CHECK);
   assign done = (state == ST_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = (num_vec == '0) ? ST_CHECK : ST_RUN;
            end
         end
         ST_RUN: begin
            if (last) begin
               state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Control state; in_ready is registered from the next state so it never
   // depends combinationally on in_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         vec_count <= '0;
         pass      <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt == ST_RUN);
         if (start_ok) begin
            vec_count <= '0;
         end else if (accept) begin
            vec_count <= cnt_inc;
         end
         if (start_ok) begin
            pass <= 1'b0;
         end else if (state == ST_CHECK) begin
            pass <= (signature == golden_q);
         end
      end
   end

   // Run parameters are plain data; they are only consulted after a start.
   always_ff @(posedge clk) begin
      if (start_ok) begin
         num_q    <= num_vec;
         golden_q <= golden;
      end
   end

   misr32 u_misr (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_ok),
      .enable (accept),
      .fold   (fold90(in_data)),
      .sig    (signature)
   );

endmodule

// File: tb/tb_expr_result_misr.sv
module tb_expr_result_misr;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_vec;
   logic [31:0] golden;
   logic        in_valid;
   logic        in_ready;
   logic [89:0] in_data;
   logic        busy;
   logic        done;
   logic        pass;
   logic [31:0] signature;
   logic [15:0] vec_count;

   int checks = 0;
   int errors = 0;

   logic [89:0] vecs[$];

   always #5 clk = ~clk;

   expr_result_misr dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_vec   (num_vec),
      .golden    (golden),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .signature (signature),
      .vec_count (vec_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [89:0] rand90();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[89:0];
   endfunction

   // Signature as a CRC-style polynomial accumulation over the vector list.
   function automatic logic [31:0] model_sig();
      logic [31:0] s;
      logic [31:0] w[3];
      logic [95:0] d;
      logic [31:0] f;
      s = 32'hFFFF_FFFF;
      foreach (vecs[k]) begin
         d = {6'd0, vecs[k]};
         for (int j = 0; j < 3; j++) w[j] = d[32*j +: 32];
         f = w[0] ^ w[1] ^ w[2];
         s = (s << 1) ^ (s[31] ? 32'h04C1_1DB7 : 32'd0) ^ f;
      end
      return s;
   endfunction

   // vmode: 0 continuous valid, 1 alternating, 2 random
   task automatic do_run(input logic [31:0] gold, input int vmode, input bit midstart);
      logic [31:0] exp_sig;
      int          n;
      int          acc;
      int          cyc;
      bit          alt;
      bit          v;
      bit          hit;
      n       = vecs.size();
      exp_sig = model_sig();
      start   = 1'b1;
      num_vec = 16'(n);
      golden  = gold;
      in_valid = 1'b0;
      @(posedge clk); #1;
      start   = 1'b0;
      num_vec = 16'($urandom);
      golden  = $urandom;
      chk("pass_cleared", pass, 0);
      chk("done_cleared", done, 0);
      chk("busy_run", busy, 1);
      chk("count_cleared", vec_count, 0);
      acc = 0;
      cyc = 0;
      alt = 1'b1;
      while (acc < n) begin
         if (cyc > 200) begin
            chk("accept_timeout", 64'(acc), 64'(n));
            break;
         end
         chk("in_ready_run", in_ready, 1);
         case (vmode)
            0:       v = 1'b1;
            1:       begin v = alt; alt = !alt; end
            default: v = 1'($urandom_range(0, 1));
         endcase
         in_valid = v;
         in_data  = v ? vecs[acc] : rand90();
         if (midstart && acc == 1) begin
            start   = 1'b1;
            num_vec = 16'd7;
         end else begin
            start = 1'b0;
         end
         hit = v && in_ready;
         @(posedge clk); #1;
         if (hit) acc++;
         chk("vec_count_run", vec_count, 64'(acc));
         cyc++;
      end
      in_valid = 1'b0;
      in_data  = rand90();
      start    = 1'b0;
      chk("in_ready_check", in_ready, 0);
      chk("busy_check", busy, 1);
      chk("done_check", done, 0);
      @(posedge clk); #1;
      chk("done", done, 1);
      chk("busy_done", busy, 0);
      chk("pass", pass, 64'(exp_sig == gold));
      chk("signature", signature, exp_sig);
      chk("vec_count_final", vec_count, 64'(n));
   endtask

   initial begin
      logic [31:0] g;
      int          nr;
      rst = 1'b1; start = 1'b0; num_vec = '0; golden = '0;
      in_valid = 1'b0; in_data = '0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_sig", signature, 32'hFFFF_FFFF);
      chk("rst_count", vec_count, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // zero-length runs
      vecs.delete();
      do_run(32'hFFFF_FFFF, 0, 1'b0);
      do_run(32'h0000_0000, 0, 1'b0);

      // single vector, zero data; literal expected signature
      vecs.delete(); vecs.push_back(90'h0);
      do_run(32'hFB3E_E249, 0, 1'b0);
      chk("single_zero_sig", signature, 32'hFB3E_E249);
      chk("single_zero_pass", pass, 1);

      // single vector, nonzero fold
      vecs.delete(); vecs.push_back(90'h1);
      do_run(32'hFB3E_E249, 0, 1'b0);
      chk("single_one_sig", signature, 32'hFB3E_E248);
      chk("single_one_pass", pass, 0);

      // backpressure with alternating valid and junk data in the gaps
      vecs.delete();
      for (int i = 0; i < 4; i++) vecs.push_back(rand90());
      g = model_sig();
      do_run(g, 1, 1'b0);

      // start pulsed mid-run is ignored
      vecs.delete();
      for (int i = 0; i < 5; i++) vecs.push_back(rand90());
      g = model_sig();
      do_run(g, 0, 1'b1);

      // back-to-back: wrong golden, then same vectors with right golden
      vecs.delete();
      for (int i = 0; i < 3; i++) vecs.push_back(rand90());
      g = model_sig();
      do_run(g ^ 32'h0000_0100, 0, 1'b0);
      do_run(g, 2, 1'b0);

      // randomized runs
      for (int r = 0; r < 8; r++) begin
         vecs.delete();
         nr = $urandom_range(1, 12);
         for (int i = 0; i < nr; i++) vecs.push_back(rand90());
         g = model_sig();
         if (r % 2 == 1) g = g ^ (32'h1 << $urandom_range(0, 31));
         do_run(g, 2, 1'(r == 3));
      end

      // asynchronous abort after 2 of 5 vectors
      vecs.delete();
      for (int i = 0; i < 5; i++) vecs.push_back(rand90());
      start = 1'b1; num_vec = 16'd5; golden = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = vecs[i];
         @(posedge clk); #1;
      end
      chk("abort_pre_count", vec_count, 2);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_sig", signature, 32'hFFFF_FFFF);
      chk("abort_count", vec_count, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_done", done, 0);
      chk("abort_pass", pass, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("after_abort_idle_busy", busy, 0);

      // fresh run after abort still works
      vecs.delete();
      for (int i = 0; i < 2; i++) vecs.push_back(rand90());
      g = model_sig();
      do_run(g, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/expr_result_misr.md
# expr_result_misr

Sequential response compactor that sits directly downstream of the combinational expression modules in the regression suite. It consumes one 90-bit `y` result vector per accepted handshake, folds it into a 32-bit multiple-input signature register (MISR) over a programmed number of vectors, and compares the final signature against a golden value. This gives one pass/fail verdict per expression test.

## Interface
- `WIDTH`, 90: width of the consumed result vector (the expression `y` bus).
- `SIG_W`, 32: signature width. Fixed at 32 for the polynomial below.
- `CNT_W`, 16: width of the vector counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a run. Sampled only in IDLE or DONE.
- `num_vec`  in  CNT_W  number of vectors in the run. Sampled on `start`.
- `golden`  in  SIG_W  expected signature. Sampled on `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `in_data`  in  WIDTH  expression result vector.
- `busy`  out  1  high in RUN and CHECK.
- `done`  out  1  high in DONE, held until the next `start` or `rst`.
- `pass`  out  1  signature matched golden. Valid while `done`.
- `signature`  out  SIG_W  current MISR value.
- `vec_count`  out  CNT_W  vectors accepted in the current run.

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
  - IDLE/DONE + `start`: latch `num_vec` and `golden`, set signature = 32'hFFFF_FFFF, clear `vec_count`, clear `pass`. Go to RUN, or to CHECK if `num_vec`==0.
  - RUN: `in_ready`=1. Each accept (`in_valid & in_ready`) updates the MISR and increments `vec_count`. The accept that makes `vec_count`==`num_vec` moves the FSM to CHECK.
  - CHECK: one cycle. Register `pass` = (signature == latched golden). Go to DONE.
  - DONE: hold all outputs until `start`.
- `start` in RUN or CHECK is ignored. Latched `num_vec` and `golden` are unaffected.
- Fold: zero-extend `in_data` to 96 bits, then XOR its three 32-bit words: fold = d[31:0]^d[63:32]^d[95:64].
- MISR update: sig_next = {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ fold.
- `vec_count` saturates at its all-ones value. It does not wrap, and it cannot exceed `num_vec` anyway.
- Inputs that arrive while `in_ready`=0 are not consumed and have no effect.

## Timing
- Reset values: state IDLE, `in_ready` 0, `busy` 0, `done` 0, `pass` 0, `signature` 32'hFFFF_FFFF, `vec_count` 0.
- `rst` asserted mid-run aborts immediately. All outputs return to reset values asynchronously, and there is no partial verdict.
- `in_ready` is a registered function of state only. It does not depend combinationally on `in_valid`.
- `signature` and `vec_count` update on the clock edge of an accept.
- Latency:
  - The last accept at edge N puts the FSM in CHECK for the cycle after N.
  - `done` and `pass` are visible after edge N+1.
  - Run of n vectors with continuous `in_valid`: `start` at edge 0, then accepts at edges 1..n, then `done` after edge n+1.
- `num_vec`==0: `start` at edge 0, CHECK, then `done` after edge 1, comparing the seed against `golden`.
- Back-to-back runs: `start` in the DONE cycle restarts at the next edge.

## Structure
- Shared package `expr_chk_pkg` holds:
  - the state enum;
  - `MISR_POLY` = 32'h04C1_1DB7 and `MISR_SEED` = 32'hFFFF_FFFF;
  - a `fold90` function.
- One sub-module, `misr32`: clock, reset, `clear`, `enable`, and a 32-bit `fold` input. It holds the register and polynomial step.
- The FSM, counter and compare stay in `expr_result_misr`. Expected size is about 150–200 lines total.

## Test plan
- Zero-length run: `num_vec`=0, `golden`=32'hFFFF_FFFF, pulse `start` -> `done`=1 and `pass`=1 two edges after start, `vec_count`=0. With `golden`=0 -> `pass`=0.
- Single vector: `num_vec`=1, `in_data`=0, `golden`=32'hFB3E_E249 -> `signature`=32'hFB3E_E249, `pass`=1.
- Single vector with nonzero fold: `num_vec`=1, `in_data`=90'h1 -> `signature`=32'hFB3E_E248. With `golden`=32'hFB3E_E249 -> `pass`=0.
- Backpressure and gaps: `num_vec`=4, `in_valid` toggled 1,0,1,0,... -> exactly 4 accepts, `vec_count`=4, and the signature equals a model fed the same 4 vectors. `in_data` changes while `in_valid`=0 must not alter the signature.
- Ignored start and abort:
  - `start` pulsed mid-run -> no restart; the count continues.
  - `rst` asserted after 2 of 5 vectors -> `busy`=0, `signature`=32'hFFFF_FFFF, `vec_count`=0 with no clock edge required.
- Back-to-back runs: a second `start` in the DONE cycle, with new `golden` -> the second verdict is independent of the first, with the seed reapplied.
